// File: rtl/gaussian_row_stream.sv
// Streaming 5-tap [1 4 6 4 1]/16 horizontal Gaussian with per-row zero padding, centre alignment
// and a show-ahead output FIFO whose free space gates both input acceptance and flush shifts.
module gaussian_row_stream #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ROW_W      = 400,
  parameter int unsigned ROWS       = 300,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_dout,
  input  logic              i_out_ready,
  output logic              o_row_done,
  output logic              o_frame_done
);

  localparam int unsigned KW = $clog2(ROW_W + 3);
  localparam int unsigned RW = $clog2(ROWS + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = DATA_W + 4;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e            r_state, w_state_next;
  logic [DATA_W-1:0] r_w [5];
  logic [KW-1:0]     r_k;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_y;
  logic              r_y_vld;
  logic              r_row_done, r_frame_done;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_hold;

  logic              w_space, w_shift, w_row_end, w_last_row, w_push, w_pop;
  logic [DATA_W-1:0] w_new;
  logic [KW-1:0]     w_k_next;
  logic [SW-1:0]     w_sum;
  logic [DATA_W-1:0] w_y;
  logic              w_unused_lsb;

  // The result in flight counts against FIFO space so a shift can never overflow it.
  assign w_space    = (r_count + CW'(r_y_vld)) < CW'(FIFO_DEPTH);
  assign w_shift    = w_space & (((r_state == StRun) & i_in_valid) | (r_state == StFlush));
  assign w_new      = (r_state == StRun) ? i_din : '0;
  assign w_k_next   = r_k + KW'(1);
  assign w_row_end  = w_shift & (r_state == StFlush) & (r_k == KW'(ROW_W + 1));
  assign w_last_row = (r_row == RW'(ROWS - 1));

  // Filter the post-shift window so the last flush result survives the end-of-row clear.
  assign w_sum = SW'(r_w[3]) + (SW'(r_w[2]) << 2) + (SW'(r_w[1]) << 2) + (SW'(r_w[1]) << 1)
               + (SW'(r_w[0]) << 2) + SW'(w_new) + SW'(8);
  assign w_y          = w_sum[SW-1:4];
  assign w_unused_lsb = ^w_sum[3:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_enable) w_state_next = StRun;
      StRun:   if (w_shift && (r_k == KW'(ROW_W - 1))) w_state_next = StFlush;
      StFlush: if (w_row_end) w_state_next = w_last_row ? StIdle : StRun;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_k          <= '0;
      r_row        <= '0;
      r_y          <= '0;
      r_y_vld      <= 1'b0;
      r_row_done   <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 5; i++) r_w[i] <= '0;
    end else begin
      r_state      <= w_state_next;
      r_row_done   <= w_row_end;
      r_frame_done <= w_row_end & w_last_row;
      r_y_vld      <= w_shift & (w_k_next >= KW'(3));
      if (w_shift) r_y <= w_y;
      if (w_row_end) begin
        r_k   <= '0;
        r_row <= w_last_row ? '0 : r_row + RW'(1);
        for (int i = 0; i < 5; i++) r_w[i] <= '0;
      end else if (w_shift) begin
        r_k    <= w_k_next;
        r_w[0] <= w_new;
        for (int i = 1; i < 5; i++) r_w[i] <= r_w[i-1];
      end
    end
  end

  assign w_push = r_y_vld;
  assign w_pop  = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= r_y;
  end

  // r_hold keeps the last popped value so dout does not change while the FIFO is empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_hold <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_in_ready   = (r_state == StRun) & w_space;
  assign o_out_valid  = (r_count != '0);
  assign o_dout       = (r_count == '0) ? r_hold : r_mem[r_rptr];
  assign o_row_done   = r_row_done;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_gaussian_row_stream.sv
// Directed and model-checked bench for gaussian_row_stream (ROW_W=8, ROWS=3, FIFO_DEPTH=4).
module tb_gaussian_row_stream;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       in_valid;
  logic [7:0] din;
  logic       out_ready = 1'b1;
  logic       o_in_ready, o_out_valid, o_row_done, o_frame_done;
  logic [7:0] o_dout;

  gaussian_row_stream #(
    .DATA_W    (8),
    .ROW_W     (8),
    .ROWS      (3),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_in_valid  (in_valid),
    .i_din       (din),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .o_dout      (o_dout),
    .i_out_ready (out_ready),
    .o_row_done  (o_row_done),
    .o_frame_done(o_frame_done)
  );

  typedef struct packed {
    logic [0:7][7:0] pix;
    logic [0:7][7:0] exp;
  } vec_t;

  vec_t       vtab [3];
  int         total = 0;
  int         bad = 0;
  int         acc_cnt = 0;
  int         row_cnt = 0;
  int         frame_cnt = 0;
  int         frame_bad = 0;
  int         rdy_mode = 0;
  logic [7:0] in_q [$];
  logic [7:0] got_q [$];
  int         exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 0: always ready, 1: random, 2: stalled
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_out_valid && out_ready) got_q.push_back(o_dout);
      if (in_valid && o_in_ready) acc_cnt++;
      if (o_row_done) row_cnt++;
      if (o_frame_done) begin
        frame_cnt++;
        if (!o_row_done) frame_bad++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gauss(input logic [0:7][7:0] r, input int j);
    int s;
    s = 8;
    for (int t = -2; t <= 2; t++) begin
      int idx;
      int c;
      idx = j + t;
      c = (t == 0) ? 6 : ((t == 1 || t == -1) ? 4 : 1);
      if (idx >= 0 && idx < 8) s += c * int'(r[idx]);
    end
    return s >> 4;
  endfunction

  task automatic push_random_row();
    logic [0:7][7:0] r;
    for (int i = 0; i < 8; i++) r[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      in_q.push_back(r[i]);
      exp_q.push_back(gauss(r, i));
    end
  endtask

  task automatic drive_pix(input logic [7:0] p);
    int t;
    t = 0;
    in_valid = 1'b1;
    din = p;
    @(negedge clk);
    while (!o_in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", o_in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_stream(input int gap_max);
    logic [7:0] p;
    while (in_q.size() > 0) begin
      p = in_q.pop_front();
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      drive_pix(p);
    end
  endtask

  task automatic collect(input string tag);
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_px%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead, exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic start_frame();
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic push_table();
    for (int v = 0; v < 3; v++)
      for (int i = 0; i < 8; i++) begin
        in_q.push_back(vtab[v].pix[i]);
        exp_q.push_back(int'(vtab[v].exp[i]));
      end
  endtask

  initial begin
    int r0, f0, a0;
    vtab[0].pix = {8{8'd100}};
    vtab[0].exp = {8'd69, 8'd94, 8'd100, 8'd100, 8'd100, 8'd100, 8'd94, 8'd69};
    vtab[1].pix = {8'd0, 8'd0, 8'd0, 8'd160, 8'd0, 8'd0, 8'd0, 8'd0};
    vtab[1].exp = {8'd0, 8'd10, 8'd40, 8'd60, 8'd40, 8'd10, 8'd0, 8'd0};
    vtab[2].pix = {8{8'd255}};
    vtab[2].exp = {8'd175, 8'd239, 8'd255, 8'd255, 8'd255, 8'd255, 8'd239, 8'd175};

    rst_n = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_dout", o_dout, 0);
    chk("rst_row_done", o_row_done, 0);
    chk("rst_frame_done", o_frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_in_ready", o_in_ready, 0);
    chk("idle_accept", acc_cnt, 0);
    in_valid = 1'b0;

    // Table frame: constant, impulse and saturated rows back to back
    r0 = row_cnt;
    f0 = frame_cnt;
    push_table();
    start_frame();
    drive_stream(0);
    collect("tab");
    chk("tab_rows", row_cnt - r0, 3);
    chk("tab_frames", frame_cnt - f0, 1);
    chk("tab_frame_align", frame_bad, 0);
    a0 = acc_cnt;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_frame_idle", o_in_ready, 0);
    chk("post_frame_accept", acc_cnt - a0, 0);
    in_valid = 1'b0;

    // Backpressure: two discarded shifts plus four outstanding results fill the budget
    rdy_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    repeat (3) push_random_row();
    r0 = row_cnt;
    f0 = frame_cnt;
    a0 = acc_cnt;
    start_frame();
    fork
      drive_stream(0);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("bp_accepted", acc_cnt - a0, 6);
        chk("bp_in_ready", o_in_ready, 0);
        chk("bp_out_valid", o_out_valid, 1);
        chk("bp_head", o_dout, exp_q[0]);
        chk("bp_no_pop", got_q.size(), 0);
        rdy_mode = 1;
      end
    join
    collect("bp");
    chk("bp_rows", row_cnt - r0, 3);
    chk("bp_frames", frame_cnt - f0, 1);

    // Random pixels with input gaps and random output stalls
    repeat (3) push_random_row();
    r0 = row_cnt;
    f0 = frame_cnt;
    start_frame();
    drive_stream(3);
    collect("rnd");
    chk("rnd_rows", row_cnt - r0, 3);
    chk("rnd_frames", frame_cnt - f0, 1);
    chk("rnd_frame_align", frame_bad, 0);

    // Reset in the middle of the second row with results parked in the FIFO
    rdy_mode = 0;
    start_frame();
    for (int i = 0; i < 8; i++) in_q.push_back(8'($urandom_range(0, 255)));
    drive_stream(0);
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) in_q.push_back(8'($urandom_range(1, 255)));
    drive_stream(0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_out_valid", o_out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", o_out_valid, 0);
    chk("async_rst_in_ready", o_in_ready, 0);
    chk("async_rst_dout", o_dout, 0);
    chk("async_rst_row_done", o_row_done, 0);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    r0 = row_cnt;
    f0 = frame_cnt;
    push_table();
    start_frame();
    drive_stream(0);
    collect("after_rst");
    chk("after_rst_rows", row_cnt - r0, 3);
    chk("after_rst_frames", frame_cnt - f0, 1);
    chk("after_rst_frame_align", frame_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
